// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the 7-segment scanner.
// Segment order is {dp,g,f,e,d,c,b,a}; glyph constants leave dp clear.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } load_state_t;

  localparam seg_t SEG_0 = 8'h3F;
  localparam seg_t SEG_1 = 8'h06;
  localparam seg_t SEG_2 = 8'h5B;
  localparam seg_t SEG_3 = 8'h4F;
  localparam seg_t SEG_4 = 8'h66;
  localparam seg_t SEG_5 = 8'h6D;
  localparam seg_t SEG_6 = 8'h7D;
  localparam seg_t SEG_7 = 8'h07;
  localparam seg_t SEG_8 = 8'h7F;
  localparam seg_t SEG_9 = 8'h6F;
  localparam seg_t SEG_A = 8'h77;
  localparam seg_t SEG_B = 8'h7C;
  localparam seg_t SEG_C = 8'h39;
  localparam seg_t SEG_D = 8'h5E;
  localparam seg_t SEG_E = 8'h79;
  localparam seg_t SEG_F = 8'h71;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t s;
    case (nibble)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble -> 7-segment glyph (a=bit0 .. g=bit6).
// Latency 0; no flow control.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  seg_t full;
  logic unused_dp;

  assign full      = hex_to_seg(nibble);
  assign glyph     = full[6:0];
  assign unused_dp = full[7];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner: dead time, PWM brightness, tear-free load.
// Outputs registered one cycle after phase/idx; load is always accepted (last one wins).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int PHASE_W     = 10,
  parameter int DEAD_CYC    = 16,
  parameter int SEG_ACT_LOW = 0,
  parameter int DIG_ACT_LOW = 0,
  localparam int IDX_W      = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic [3:0]            bright,
  output logic [7:0]            seg_out,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic [IDX_W-1:0]      dig_idx,
  output logic                  load_pend,
  output logic                  frame_done
);

  localparam logic [PHASE_W-1:0]  DEAD_P   = PHASE_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [7:0]          SEG_OFF  = {8{SEG_ACT_LOW != 0}};
  localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACT_LOW != 0}};

  logic [PHASE_W-1:0]    phase;
  logic [IDX_W-1:0]      idx;
  logic                  phase_wrap;
  logic                  boundary;

  logic [4*N_DIGITS-1:0] sh_digits, act_digits;
  logic [N_DIGITS-1:0]   sh_dp, act_dp;
  logic [N_DIGITS-1:0]   sh_blank, act_blank;

  load_state_t           state, state_nx;
  logic                  commit_shadow;
  logic                  commit_direct;

  logic [3:0]            cur_nib;
  logic [6:0]            cur_glyph;
  logic [N_DIGITS-1:0]   onehot;
  logic                  lit;

  assign phase_wrap = &phase;
  assign boundary   = phase_wrap && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      idx   <= '0;
    end else begin
      phase <= phase + 1'b1;
      if (phase_wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LD_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A load landing on the boundary bypasses the shadow so it is not delayed a frame.
  always_comb begin
    state_nx      = state;
    commit_shadow = 1'b0;
    commit_direct = 1'b0;
    case (state)
      LD_IDLE: begin
        if (load) begin
          if (boundary) commit_direct = 1'b1;
          else          state_nx      = LD_PEND;
        end
      end
      LD_PEND: begin
        if (boundary) begin
          state_nx = LD_IDLE;
          if (load) commit_direct = 1'b1;
          else      commit_shadow = 1'b1;
        end
      end
      default: state_nx = LD_IDLE;
    endcase
  end

  assign load_pend = (state == LD_PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
    end else if (load) begin
      sh_digits <= digits_in;
      sh_dp     <= dp_in;
      sh_blank  <= blank_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_digits <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else if (commit_direct) begin
      act_digits <= digits_in;
      act_dp     <= dp_in;
      act_blank  <= blank_in;
    end else if (commit_shadow) begin
      act_digits <= sh_digits;
      act_dp     <= sh_dp;
      act_blank  <= sh_blank;
    end
  end

  assign cur_nib = act_digits[{idx, 2'b00} +: 4];

  hex7seg_decode u_decode (
    .nibble (cur_nib),
    .glyph  (cur_glyph)
  );

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  assign lit = (phase >= DEAD_P) &&
               (phase[PHASE_W-1 -: 4] < bright) &&
               !act_blank[idx];

  // Segments and digit enable switch together, so a lit digit never sees a segment change.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_OFF;
      dig_sel    <= DIG_OFF;
      dig_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= (lit ? {act_dp[idx], cur_glyph} : 8'h00) ^ SEG_OFF;
      dig_sel    <= (lit ? onehot : '0) ^ DIG_OFF;
      dig_idx    <= idx;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-count reference model feeding a scoreboard queue.
// Three instances share the clock: N=8 active-high, N=8 active-low, N=6.
module tb_seg7_scan_ctrl;

  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank = '0;
  logic [3:0]  bright = 4'd15;

  logic [7:0] seg, seg_i, seg6;
  logic [7:0] dig, dig_i;
  logic [5:0] dig6;
  logic [2:0] idx, idx_i, idx6;
  logic       pend, pend_i, pend6;
  logic       fd, fd_i, fd6;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.N_DIGITS(8), .PHASE_W(4), .DEAD_CYC(DEAD), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) u_dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits), .dp_in(dp), .blank_in(blank),
    .bright(bright), .seg_out(seg), .dig_sel(dig), .dig_idx(idx), .load_pend(pend), .frame_done(fd));

  seg7_scan_ctrl #(.N_DIGITS(8), .PHASE_W(4), .DEAD_CYC(DEAD), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) u_inv (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits), .dp_in(dp), .blank_in(blank),
    .bright(bright), .seg_out(seg_i), .dig_sel(dig_i), .dig_idx(idx_i), .load_pend(pend_i), .frame_done(fd_i));

  seg7_scan_ctrl #(.N_DIGITS(6), .PHASE_W(4), .DEAD_CYC(DEAD), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) u_six (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits[23:0]), .dp_in(dp[5:0]), .blank_in(blank[5:0]),
    .bright(bright), .seg_out(seg6), .dig_sel(dig6), .dig_idx(idx6), .load_pend(pend6), .frame_done(fd6));

  typedef struct {
    logic [7:0] seg;
    logic [7:0] dig;
    logic [2:0] idx;
    logic       pend;
    logic       fd;
    logic [2:0] idx6;
    logic       fd6;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         c = 0;
  logic [7:0] glyph [16];
  logic [3:0] m_dig [8];
  logic [3:0] s_dig [8];
  logic [7:0] m_dp, m_blank, s_dp, s_blank;
  logic       m_pend;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_dig[k] = 4'h0;
      s_dig[k] = 4'h0;
    end
    m_dp = 8'h00; s_dp = 8'h00;
    m_blank = 8'hFF; s_blank = 8'hFF;
    m_pend = 1'b0;
    sb.delete();
    c = 0;
  endtask

  // Predict the outputs that follow the next edge, update the model, advance one clock.
  task automatic cycle();
    exp_t e;
    int   ph, ix;
    bit   lit, bnd;
    ph  = c % 16;
    ix  = (c / 16) % 8;
    lit = (ph >= DEAD) && (ph < int'(bright)) && !m_blank[ix];
    e.dig  = lit ? (8'h01 << ix) : 8'h00;
    e.seg  = lit ? (glyph[m_dig[ix]] | (m_dp[ix] ? 8'h80 : 8'h00)) : 8'h00;
    e.idx  = 3'(ix);
    e.fd   = (c % 128) == 127;
    e.idx6 = 3'((c / 16) % 6);
    e.fd6  = (c % 96) == 95;
    bnd    = e.fd;
    if (load) begin
      for (int k = 0; k < 8; k++) s_dig[k] = digits[4*k +: 4];
      s_dp = dp; s_blank = blank;
      if (bnd) begin
        for (int k = 0; k < 8; k++) m_dig[k] = s_dig[k];
        m_dp = s_dp; m_blank = s_blank; m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (bnd && m_pend) begin
      for (int k = 0; k < 8; k++) m_dig[k] = s_dig[k];
      m_dp = s_dp; m_blank = s_blank; m_pend = 1'b0;
    end
    e.pend = m_pend;
    sb.push_back(e);
    @(posedge clk);
    c++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (seg !== 8'h00) begin errors++; $display("FAIL reset_seg got %02h exp 00", seg); end
    checks++; if (dig !== 8'h00) begin errors++; $display("FAIL reset_dig got %02h exp 00", dig); end
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend); end
    checks++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", fd); end
    checks++; if (seg_i !== 8'hFF) begin errors++; $display("FAIL reset_seg_inv got %02h exp FF", seg_i); end
    checks++; if (dig_i !== 8'hFF) begin errors++; $display("FAIL reset_dig_inv got %02h exp FF", dig_i); end
    checks++; if ({seg6, dig6, pend6} !== 15'h0) begin errors++; $display("FAIL reset_six got %h exp 0", {seg6, dig6, pend6}); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_scan();
    exp_t e;
    bit   saw;
    saw = 1'b0;
    digits = 32'h7654_3210; dp = 8'h00; blank = 8'h00; bright = 4'd15; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb.pop_front();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL scan_pend got %b exp 1", pend); end
    for (int i = 0; i < 300; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (idx !== e.idx) begin errors++; $display("FAIL scan_idx c=%0d got %0d exp %0d", c, idx, e.idx); end
      checks++; if (fd !== e.fd) begin errors++; $display("FAIL scan_fd c=%0d got %b exp %b", c, fd, e.fd); end
      checks++; if (pend !== e.pend) begin errors++; $display("FAIL scan_pend c=%0d got %b exp %b", c, pend, e.pend); end
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL scan_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
      checks++; if (dig !== e.dig) begin errors++; $display("FAIL scan_dig c=%0d got %02h exp %02h", c, dig, e.dig); end
      checks++; if ($countones(dig) > 1) begin errors++; $display("FAIL scan_onehot c=%0d got %02h exp at most one bit", c, dig); end
      if (e.idx == 3'd3 && dig == 8'h08 && seg == 8'h4F) saw = 1'b1;
    end
    checks++; if (!saw) begin errors++; $display("FAIL scan_digit3 got no 4F on digit 3 exp 4F"); end
  endtask

  task automatic test_bright();
    exp_t e;
    int   nfd;
    nfd = 0;
    bright = 4'd0;
    for (int i = 0; i < 128; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (dig !== 8'h00) begin errors++; $display("FAIL bright0_dig c=%0d got %02h exp 00", c, dig); end
      checks++; if (fd !== e.fd) begin errors++; $display("FAIL bright0_fd c=%0d got %b exp %b", c, fd, e.fd); end
      nfd += int'(fd);
    end
    checks++; if (nfd != 1) begin errors++; $display("FAIL bright0_frames got %0d exp 1", nfd); end
    bright = 4'd8;
    for (int i = 0; i < 48; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (dig !== e.dig) begin errors++; $display("FAIL bright8_dig c=%0d got %02h exp %02h", c, dig, e.dig); end
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL bright8_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
    end
    bright = 4'd15;
  endtask

  task automatic test_load();
    exp_t e;
    bit   saw77, saw7c;
    saw77 = 1'b0; saw7c = 1'b0;
    while (c % 128 != 40) begin
      cycle();
      e = sb.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL load_pre_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
    end
    digits = 32'h7654_321A; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb.pop_front();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL load_mid_pend got %b exp 1", pend); end
    for (int i = 0; i < 160; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL load_mid_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
      checks++; if (pend !== e.pend) begin errors++; $display("FAIL load_mid_pend c=%0d got %b exp %b", c, pend, e.pend); end
      if (e.idx == 3'd0 && dig == 8'h01 && seg == 8'h77) saw77 = 1'b1;
    end
    checks++; if (!saw77) begin errors++; $display("FAIL load_mid_glyph got no 77 on digit 0 exp 77"); end
    while (c % 128 != 127) begin
      cycle();
      e = sb.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL load_wait_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
    end
    digits = 32'h7654_321B; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb.pop_front();
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL load_bnd_pend got %b exp 0", pend); end
    checks++; if (fd !== 1'b1) begin errors++; $display("FAIL load_bnd_fd got %b exp 1", fd); end
    for (int i = 0; i < 20; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL load_bnd_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
      if (e.idx == 3'd0 && dig == 8'h01 && seg == 8'h7C) saw7c = 1'b1;
    end
    checks++; if (!saw7c) begin errors++; $display("FAIL load_bnd_glyph got no 7C on digit 0 exp 7C"); end
  endtask

  task automatic test_blank_dp();
    exp_t e;
    bit   sawdp;
    sawdp = 1'b0;
    digits = 32'h7654_3210; dp = 8'h80; blank = 8'h05; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 300; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (seg !== e.seg) begin errors++; $display("FAIL blank_seg c=%0d got %02h exp %02h", c, seg, e.seg); end
      checks++; if (dig !== e.dig) begin errors++; $display("FAIL blank_dig c=%0d got %02h exp %02h", c, dig, e.dig); end
      checks++; if (seg_i !== ~e.seg) begin errors++; $display("FAIL blank_seg_inv c=%0d got %02h exp %02h", c, seg_i, ~e.seg); end
      checks++; if (dig_i !== ~e.dig) begin errors++; $display("FAIL blank_dig_inv c=%0d got %02h exp %02h", c, dig_i, ~e.dig); end
      if (e.idx == 3'd7 && dig == 8'h80 && seg[7]) sawdp = 1'b1;
    end
    checks++; if (!sawdp) begin errors++; $display("FAIL blank_dp7 got no dp on digit 7 exp dp lit"); end
  endtask

  task automatic test_six();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (idx6 !== e.idx6) begin errors++; $display("FAIL six_idx c=%0d got %0d exp %0d", c, idx6, e.idx6); end
      checks++; if (fd6 !== e.fd6) begin errors++; $display("FAIL six_fd c=%0d got %b exp %b", c, fd6, e.fd6); end
      checks++; if (idx6 > 3'd5) begin errors++; $display("FAIL six_range c=%0d got %0d exp below 6", c, idx6); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    while (c % 128 != 55) begin
      cycle();
      e = sb.pop_front();
    end
    digits = 32'h0000_0000; dp = 8'h00; blank = 8'h00; load = 1'b1;
    cycle();
    load = 1'b0;
    e = sb.pop_front();
    checks++; if (dig !== e.dig) begin errors++; $display("FAIL rmid_pre_dig got %02h exp %02h", dig, e.dig); end
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rmid_pre_pend got %b exp 1", pend); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (seg !== 8'h00) begin errors++; $display("FAIL rmid_seg got %02h exp 00", seg); end
    checks++; if (dig !== 8'h00) begin errors++; $display("FAIL rmid_dig got %02h exp 00", dig); end
    checks++; if (idx !== 3'd0) begin errors++; $display("FAIL rmid_idx got %0d exp 0", idx); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rmid_pend got %b exp 0", pend); end
    checks++; if (seg_i !== 8'hFF) begin errors++; $display("FAIL rmid_seg_inv got %02h exp FF", seg_i); end
    checks++; if (dig_i !== 8'hFF) begin errors++; $display("FAIL rmid_dig_inv got %02h exp FF", dig_i); end
    model_reset();
    for (int i = 0; i < 140; i++) begin
      cycle();
      e = sb.pop_front();
      checks++; if (dig !== e.dig) begin errors++; $display("FAIL rmid_post_dig c=%0d got %02h exp %02h", c, dig, e.dig); end
      checks++; if (pend !== e.pend) begin errors++; $display("FAIL rmid_post_pend c=%0d got %b exp %b", c, pend, e.pend); end
      checks++; if (idx !== e.idx) begin errors++; $display("FAIL rmid_post_idx c=%0d got %0d exp %0d", c, idx, e.idx); end
    end
  endtask

  initial begin
    glyph = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    model_reset();
    test_reset();
    test_scan();
    test_bright();
    test_load();
    test_blank_dp();
    test_six();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached at c=%0d", c);
    $fatal(1, "watchdog");
  end

endmodule
